// File: rtl/shift_recover_pkg.sv
// ============================================================================
// Module  : shift_pkg
// Brief   : Shared types, widths and key-rotation helper for shift_recover.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

  localparam int KEY_W   = 8;
  localparam int WORD_W  = 32;
  localparam int PHASE_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [KEY_W-1:0] rotl1(input logic [KEY_W-1:0] k);
    return {k[KEY_W-2:0], k[KEY_W-1]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_recover_outreg.sv
// ============================================================================
// Module  : shift_recover_outreg
// Brief   : Single-entry valid/ready output register for recovered beats.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_recover_outreg
  import shift_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WORD_W-1:0]  in_data,
  input  logic [KEY_W-1:0]   in_key,
  input  logic [PHASE_W-1:0] in_phase,
  input  logic               in_err,
  output logic               ready,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WORD_W-1:0]  out_data,
  output logic [KEY_W-1:0]   out_key,
  output logic [PHASE_W-1:0] out_phase,
  output logic               out_err
);

  logic               valid_q, valid_d;
  logic [WORD_W-1:0]  data_q,  data_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               err_q,   err_d;

  // Push is only issued when ready is high, so a held beat is never overwritten.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    key_d   = key_q;
    phase_d = phase_q;
    err_d   = err_q;
    if (push) begin
      valid_d = 1'b1;
      data_d  = in_data;
      key_d   = in_key;
      phase_d = in_phase;
      err_d   = in_err;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      key_q   <= '0;
      phase_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      key_q   <= key_d;
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  assign ready     = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_key   = key_q;
  assign out_phase = phase_q;
  assign out_err   = err_q;

endmodule

`default_nettype wire

// File: rtl/shift_recover.sv
// ============================================================================
// Module  : shift_recover
// Brief   : Undoes sender negation and re-tracks the rotating key of the
//           shift/negate adder stream. Define SHIFT_RECOVER_CHECK_EN to build
//           the key-tag compare (out_err / err_flag).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_recover
  import shift_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_load,
  input  logic               in_sub,
  input  logic [WORD_W-1:0]  in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic [KEY_W-1:0]   out_key,
  output logic [PHASE_W-1:0] out_phase,
  output logic               out_err,
  output logic               err_flag,
  output logic [CNT_W-1:0]   drop_cnt
);

  state_e             state_q, state_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic [WORD_W-1:0]  word;
  logic [KEY_W-1:0]   key_rot;
  logic               accept;
  logic               push;
  logic               tag_err;
  logic               beat_err;

  assign word    = in_sub ? (WORD_W'(0) - in_sum) : in_sum;
  assign key_rot = rotl1(key_q);
  assign accept  = in_valid && in_ready;

`ifdef SHIFT_RECOVER_CHECK_EN
  logic err_flag_q, err_flag_d;

  assign tag_err    = (word[WORD_W-1 -: KEY_W] != key_rot);
  assign err_flag_d = err_flag_q | beat_err;

  always_ff @(posedge clk) begin
    if (reset) err_flag_q <= 1'b0;
    else       err_flag_q <= err_flag_d;
  end

  assign err_flag = err_flag_q;
`else
  assign tag_err  = 1'b0;
  assign err_flag = 1'b0;
`endif

  // A load beat always takes priority over rotation, in either state.
  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    phase_d    = phase_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    beat_err   = 1'b0;
    if (accept) begin
      if (in_load) begin
        state_d = ST_RUN;
        key_d   = word[KEY_W-1:0];
        phase_d = '0;
        push    = 1'b1;
      end else if (state_q == ST_RUN) begin
        key_d    = key_rot;
        phase_d  = phase_q + PHASE_W'(1);
        push     = 1'b1;
        beat_err = tag_err;
      end else if (drop_cnt_q != {CNT_W{1'b1}}) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      key_q      <= '0;
      phase_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      phase_q    <= phase_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;

  shift_recover_outreg u_outreg (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .in_data   (word),
    .in_key    (key_d),
    .in_phase  (phase_d),
    .in_err    (beat_err),
    .ready     (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_key   (out_key),
    .out_phase (out_phase),
    .out_err   (out_err)
  );

endmodule

`default_nettype wire

// File: doc/shift_recover.md
# shift_recover

Receive-side counterpart of the shift/negate adder datapath. Accepts the 32-bit result stream that carries a conditionally negated word and an 8-bit left-rotating key. Undoes the negation, re-tracks the rotating key, and presents recovered words with their key phase on a registered valid/ready output. Sits between the adder output bus and the downstream consumer.

## Interface
Parameters:
- CNT_W, default 16: width of the dropped-beat counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept the input beat.
- in_load  in  1  beat is a key-load beat; word[7:0] carries the new key.
- in_sub  in  1  beat was negated by the sender.
- in_sum  in  32  input word.
- out_valid  out  1  recovered beat present.
- out_ready  in  1  consumer accepts the recovered beat.
- out_data  out  32  recovered word.
- out_key  out  8  key value associated with the beat.
- out_phase  out  3  rotation count since the last load, modulo 8.
- out_err  out  1  key-tag mismatch on this beat (CHECK_EN only).
- err_flag  out  1  sticky mismatch flag (CHECK_EN only).
- drop_cnt  out  CNT_W  count of beats discarded while no key is held; saturates.

## Operation
- Recovered word: word = in_sub ? (32'h0 − in_sum) mod 2^32 : in_sum.
  - Negation of 0 yields 0.
  - Negation of 32'h8000_0000 yields 32'h8000_0000.
- FSM states: IDLE (no key held) and RUN (key held).
- Accept condition: in_valid && in_ready.
- IDLE:
  - Accepted non-load beat: dropped, no output; drop_cnt increments and saturates at all-ones.
  - Accepted load beat: key ← word[7:0], phase ← 0, go to RUN. Emits an output beat with out_key = new key and out_phase = 0.
- RUN:
  - Accepted non-load beat: key ← {key[6:0], key[7]} and phase ← phase + 1 (wraps 7→0). Emits an output beat carrying the post-rotation key and phase.
  - Accepted load beat: reloads the key and phase as in IDLE and emits an output beat. A load always wins over rotation.
- Rotation and phase advance only on accepted beats. Stalls freeze the key and phase.
- Reset: state IDLE, key 0, phase 0, out_valid 0, out_data 0, out_key 0, out_phase 0, out_err 0, err_flag 0, drop_cnt 0.
  - A beat presented in the same cycle as reset is discarded.

## Timing
- Latency: one cycle from the accepted input beat to out_valid.
- Output register with single-entry buffer: in_ready = !out_valid || out_ready. Full throughput of one beat per cycle when out_ready is held high.
- While out_valid && !out_ready, all out_* signals hold stable.
- In IDLE, a dropped beat still needs in_ready. No bubble is inserted for dropped beats.
- drop_cnt and err_flag update in the cycle the beat is accepted and are visible on the next cycle.

## Configuration
- SHIFT_RECOVER_CHECK_EN defined:
  - On every accepted non-load beat in RUN, compare word[31:24] with the post-rotation key.
  - Mismatch sets out_err on that output beat and sets err_flag.
  - err_flag clears only on reset.
- SHIFT_RECOVER_CHECK_EN undefined: out_err and err_flag are tied 0 and no compare logic is built.

## Structure
- Shared package shift_pkg holds:
  - The FSM state enum (ST_IDLE, ST_RUN).
  - KEY_W = 8, WORD_W = 32, PHASE_W = 3.
  - The rotate-left-by-one function.
- One sub-module, shift_recover_outreg: the valid/ready output register carrying {data, key, phase, err}. The top level holds the negation, the FSM, the key tracker and the counter.

## Test plan
- Reset then non-load beats in_sum = 5, 6, 7 → no output beats, drop_cnt = 3, state stays IDLE.
- Load beat with in_sub=0, in_sum=0x0000_0081, then two non-load beats → outputs in order:
  - key 0x81, phase 0.
  - key 0x03, phase 1.
  - key 0x06, phase 2.
- Negation: non-load beat with in_sub=1, in_sum=0xFFFF_FFFF → out_data 0x0000_0001. Beat with in_sub=1, in_sum=0x8000_0000 → out_data 0x8000_0000.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 → in_ready falls after the first beat, outputs stay stable, key does not rotate. On release, beats arrive in order with no loss or duplication.
- Wrap and reload: 8 non-load beats after loading key 0x01 → phase returns to 0 and key to 0x01. A load of 0x5A mid-stream → key 0x5A, phase 0.
- With CHECK_EN, load key 0x01, then non-load word 0x0200_0000 → out_err 0. Then word 0x0000_0000 → out_err 1 and err_flag stays 1 until reset.
